// File: rtl/shared_vram_arbiter.sv
// Shared video RAM arbiter between main CPU A and sub CPU B.
// Round-robin grant, Z80 WAIT stretching and VRAM write strobe.
module shared_vram_arbiter #(
  parameter int ACC_CYCLES = 2,
  parameter int CNT_W      = 3,
  parameter bit PARK_SEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a_req,
  input  logic a_wr,
  input  logic b_req,
  input  logic b_wr,
  output logic ab_sel,
  output logic a_wait_n,
  output logic b_wait_n,
  output logic vram_we_n,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_A,
    S_DONE_A,
    S_ACC_B,
    S_DONE_B
  } state_t;

  localparam logic [CNT_W-1:0] LP_LOAD = CNT_W'(ACC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel;
  logic             r_we_n;
  logic             r_busy;
  // 0 = A was granted last, 1 = B was granted last
  logic             r_last;

  state_t           w_nstate;
  logic [CNT_W-1:0] w_ncnt;
  logic             w_nsel;
  logic             w_nwe_n;
  logic             w_nlast;

  // Next state: grant, access countdown, abort and hand-over
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nsel   = r_sel;
    w_nwe_n  = 1'b1;
    w_nlast  = r_last;
    unique case (r_state)
      S_IDLE: begin
        if (a_req && (!b_req || r_last)) begin
          w_nstate = S_ACC_A;
          w_ncnt   = LP_LOAD;
          w_nsel   = 1'b0;
          w_nwe_n  = ~a_wr;
        end else if (b_req) begin
          w_nstate = S_ACC_B;
          w_ncnt   = LP_LOAD;
          w_nsel   = 1'b1;
          w_nwe_n  = ~b_wr;
        end
      end
      S_ACC_A: begin
        if (r_cnt == '0) begin
          w_nstate = S_DONE_A;
        end else if (!a_req) begin
          w_nstate = S_IDLE;
          w_nlast  = 1'b0;
        end else begin
          w_ncnt  = r_cnt - LP_ONE;
          w_nwe_n = ~a_wr;
        end
      end
      S_DONE_A: begin
        if (!a_req) begin
          w_nlast = 1'b0;
          if (b_req) begin
            w_nstate = S_ACC_B;
            w_ncnt   = LP_LOAD;
            w_nsel   = 1'b1;
            w_nwe_n  = ~b_wr;
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      S_ACC_B: begin
        if (r_cnt == '0) begin
          w_nstate = S_DONE_B;
        end else if (!b_req) begin
          w_nstate = S_IDLE;
          w_nlast  = 1'b1;
        end else begin
          w_ncnt  = r_cnt - LP_ONE;
          w_nwe_n = ~b_wr;
        end
      end
      S_DONE_B: begin
        if (!b_req) begin
          w_nlast = 1'b1;
          if (a_req) begin
            w_nstate = S_ACC_A;
            w_ncnt   = LP_LOAD;
            w_nsel   = 1'b0;
            w_nwe_n  = ~a_wr;
          end else begin
            w_nstate = S_IDLE;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= PARK_SEL;
      r_we_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_sel   <= w_nsel;
      r_we_n  <= w_nwe_n;
      r_busy  <= (w_nstate != S_IDLE);
      r_last  <= w_nlast;
    end
  end

  assign ab_sel    = r_sel;
  assign vram_we_n = r_we_n;
  assign busy      = r_busy;

  // WAIT is combinational so it can be asserted in the same T-state
  assign a_wait_n = reset | ~(a_req & (r_state != S_DONE_A));
  assign b_wait_n = reset | ~(b_req & (r_state != S_DONE_B));

endmodule

// File: tb/tb_shared_vram_arbiter.sv
// Testbench for shared_vram_arbiter.
// Vector table with scoreboard queue, plus a reactive hand-over sequence.
module tb_shared_vram_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic a_req0, a_wr0, b_req0, b_wr0;
  logic sel0, aw0, bw0, we0, busy0;
  logic a_req1, a_wr1, b_req1, b_wr1;
  logic sel1, aw1, bw1, we1, busy1;

  always #5 clk = ~clk;

  shared_vram_arbiter #(
    .ACC_CYCLES(2), .CNT_W(3), .PARK_SEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req0), .a_wr(a_wr0),
    .b_req(b_req0), .b_wr(b_wr0),
    .ab_sel(sel0), .a_wait_n(aw0), .b_wait_n(bw0),
    .vram_we_n(we0), .busy(busy0)
  );

  shared_vram_arbiter #(
    .ACC_CYCLES(1), .CNT_W(3), .PARK_SEL(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req1), .a_wr(a_wr1),
    .b_req(b_req1), .b_wr(b_wr1),
    .ab_sel(sel1), .a_wait_n(aw1), .b_wait_n(bw1),
    .vram_we_n(we1), .busy(busy1)
  );

  // exp = {ab_sel, a_wait_n, b_wait_n, vram_we_n, busy}
  typedef struct {
    bit       u;
    bit       rst;
    bit       ar;
    bit       aw;
    bit       br;
    bit       bw;
    bit [4:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] sb[$];
  int         n_chk = 0;
  int         n_err = 0;
  string      nm[5] = '{"ab_sel", "a_wait_n", "b_wait_n",
                        "vram_we_n", "busy"};

  function automatic void add(bit u, bit rst, bit ar, bit aw,
                              bit br, bit bw, bit s, bit awn,
                              bit bwn, bit we, bit bsy);
    vec_t v;
    v.u = u; v.rst = rst; v.ar = ar; v.aw = aw;
    v.br = br; v.bw = bw;
    v.exp = {s, awn, bwn, we, bsy};
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    logic [4:0] got;
    logic [4:0] e;
    int wlow, welow;
    bit done;

    reset = 1'b1;
    a_req0 = 0; a_wr0 = 0; b_req0 = 0; b_wr0 = 0;
    a_req1 = 0; a_wr1 = 0; b_req1 = 0; b_wr1 = 0;

    // reset: waits released regardless of requests
    add(0,1,1,1,1,1, 0,1,1,1,0);
    // single A write
    add(0,0,1,1,0,0, 0,0,1,1,0);
    add(0,0,1,1,0,0, 0,0,1,0,1);
    add(0,0,1,1,0,0, 0,0,1,0,1);
    add(0,0,1,1,0,0, 0,1,1,1,1);
    add(0,0,1,1,0,0, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,0);
    // tie after reset: A first, B directly after
    add(0,1,0,0,0,0, 0,1,1,1,0);
    add(0,0,1,0,1,1, 0,0,0,1,0);
    add(0,0,1,0,1,1, 0,0,0,1,1);
    add(0,0,1,0,1,1, 0,0,0,1,1);
    add(0,0,0,0,1,1, 0,1,0,1,1);
    add(0,0,0,0,1,1, 1,1,0,0,1);
    add(0,0,0,0,1,1, 1,1,0,0,1);
    add(0,0,0,0,1,1, 1,1,1,1,1);
    add(0,0,0,0,0,0, 1,1,1,1,1);
    add(0,0,0,0,0,0, 1,1,1,1,0);
    // continuous ties: A, B, A, B
    add(0,0,1,0,1,0, 1,0,0,1,0);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,0,0,1,0, 0,1,0,1,1);
    add(0,0,1,0,1,0, 1,0,0,1,1);
    add(0,0,1,0,1,0, 1,0,0,1,1);
    add(0,0,1,0,0,0, 1,0,1,1,1);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,0,0,1,0, 0,1,0,1,1);
    add(0,0,1,0,1,0, 1,0,0,1,1);
    add(0,0,1,0,1,0, 1,0,0,1,1);
    add(0,0,0,0,0,0, 1,1,1,1,1);
    add(0,0,0,0,0,0, 1,1,1,1,0);
    // single A read so that A is last grant
    add(0,0,1,0,0,0, 1,0,1,1,0);
    add(0,0,1,0,0,0, 0,0,1,1,1);
    add(0,0,1,0,0,0, 0,0,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,0);
    // B write aborted in first ACC cycle; next tie to A
    add(0,0,0,0,1,1, 0,1,0,1,0);
    add(0,0,0,0,0,0, 1,1,1,0,1);
    add(0,0,1,0,1,0, 1,0,0,1,0);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,1,0,1,0, 0,0,0,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,0);
    // reset during ACC_A write
    add(0,0,1,1,0,0, 0,0,1,1,0);
    add(0,0,1,1,0,0, 0,0,1,0,1);
    add(0,1,1,1,0,0, 0,1,1,0,1);
    add(0,0,1,1,0,0, 0,0,1,1,0);
    add(0,0,1,1,0,0, 0,0,1,0,1);
    add(0,0,1,1,0,0, 0,0,1,0,1);
    add(0,0,0,0,0,0, 0,1,1,1,1);
    add(0,0,0,0,0,0, 0,1,1,1,0);
    // reset during ACC_B write: ab_sel back to park
    add(0,0,0,0,1,1, 0,1,0,1,0);
    add(0,0,0,0,1,1, 1,1,0,0,1);
    add(0,1,0,0,1,1, 1,1,1,0,1);
    add(0,0,0,0,0,0, 0,1,1,1,0);
    // ACC_CYCLES=1: B read, then A write
    add(1,0,0,0,1,0, 0,1,0,1,0);
    add(1,0,0,0,1,0, 1,1,0,1,1);
    add(1,0,0,0,0,0, 1,1,1,1,1);
    add(1,0,0,0,0,0, 1,1,1,1,0);
    add(1,0,1,1,0,0, 1,0,1,1,0);
    add(1,0,1,1,0,0, 0,0,1,0,1);
    add(1,0,0,0,0,0, 0,1,1,1,1);
    add(1,0,0,0,0,0, 0,1,1,1,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      reset  = tbl[i].rst;
      a_req0 = tbl[i].u ? 1'b0 : tbl[i].ar;
      a_wr0  = tbl[i].u ? 1'b0 : tbl[i].aw;
      b_req0 = tbl[i].u ? 1'b0 : tbl[i].br;
      b_wr0  = tbl[i].u ? 1'b0 : tbl[i].bw;
      a_req1 = tbl[i].u ? tbl[i].ar : 1'b0;
      a_wr1  = tbl[i].u ? tbl[i].aw : 1'b0;
      b_req1 = tbl[i].u ? tbl[i].br : 1'b0;
      b_wr1  = tbl[i].u ? tbl[i].bw : 1'b0;
      sb.push_back(tbl[i].exp);
      @(negedge clk);
      if (tbl[i].u)
        got = {sel1, aw1, bw1, we1, busy1};
      else
        got = {sel0, aw0, bw0, we0, busy0};
      e = sb.pop_front();
      for (int k = 0; k < 5; k++)
        chk($sformatf("v%0d %s", i, nm[k]),
            32'(got[4-k]), 32'(e[4-k]));
    end

    // Reactive tie: A read then B write, A ends its cycle on WAIT
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_req0 = 1; a_wr0 = 0; b_req0 = 1; b_wr0 = 1;
    wlow = 0; welow = 0; done = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (!we0) welow++;
      if (bw0) done = 1;
      else wlow++;
      if (aw0 && a_req0) a_req0 = 0;
    end
    chk("seq b released", 32'(done), 32'd1);
    chk("seq b wait cycles", 32'(wlow), 32'd6);
    chk("seq we low cycles", 32'(welow), 32'd2);
    chk("seq sel in done_b", 32'(sel0), 32'd1);
    b_req0 = 0; b_wr0 = 0;
    @(negedge clk);
    chk("seq busy idle", 32'(busy0), 32'd0);
    chk("seq sel parked", 32'(sel0), 32'd1);
    chk("seq we idle", 32'(we0), 32'd1);
    chk("sb drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shared_vram_arbiter.md
Name: shared_vram_arbiter

Overview:
- Sequences access to the shared video RAM between main CPU A and sub CPU B.
- Generates the AB_Sel bus-owner select that feeds the shared-VRAM chip-select/read decoder.
- Also generates per-CPU Z80 WAIT stretching and the VRAM write strobe.
- Sits between each CPU's region decode (request) and the VRAM address/data muxes.

Parameters:
- ACC_CYCLES, 2: clk cycles the granted CPU owns the RAM before its WAIT is released (1..7).
- CNT_W, 3: width of the access counter; must hold ACC_CYCLES-1.
- PARK_SEL, 0: ab_sel value after reset (0 = CPU A, 1 = CPU B).

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- a_req  in  1  CPU A addresses shared VRAM region (decoded MREQ+range), held for the whole bus cycle.
- a_wr  in  1  CPU A cycle is a write.
- b_req  in  1  CPU B shared VRAM request, same rules.
- b_wr  in  1  CPU B cycle is a write.
- ab_sel  out  1  bus owner select: 0 = A, 1 = B.
- a_wait_n  out  1  Z80 WAIT to CPU A, low = stretch.
- b_wait_n  out  1  Z80 WAIT to CPU B.
- vram_we_n  out  1  shared VRAM write strobe, active low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: state IDLE, ab_sel = PARK_SEL, vram_we_n = 1, busy = 0, cnt = 0, last_grant = B (A wins the first tie).
- While reset = 1: a_wait_n = b_wait_n = 1, regardless of requests.
- States: IDLE, ACC_A, DONE_A, ACC_B, DONE_B.
- IDLE:
  - only a_req → ACC_A; only b_req → ACC_B.
  - both → the CPU that is not last_grant.
  - none → stay; ab_sel holds its last value (parking).
  - On entry to ACC_x: ab_sel = x and cnt = ACC_CYCLES-1, registered on the same edge.
- ACC_x:
  - cnt decrements each cycle; at cnt == 0 → DONE_x next edge.
  - vram_we_n = ~x_wr (registered with the state, so low for exactly ACC_CYCLES cycles on a write).
  - If x_req drops before cnt == 0 → IDLE next edge (abort): vram_we_n = 1, last_grant = x.
- DONE_x:
  - vram_we_n = 1; ab_sel held so read data stays valid until the CPU ends its cycle.
  - Stay while x_req = 1.
  - When x_req = 0: last_grant = x. If the other CPU is requesting → ACC_other directly (no IDLE bubble); else → IDLE.
- WAIT is combinational, for zero-latency assertion at Z80 T2:
  - a_wait_n = ~(a_req & state != DONE_A);
  - b_wait_n = ~(b_req & state != DONE_B).
  - A losing or pending requester therefore stays stretched until its own DONE state.
- busy = (state != IDLE), registered.
- Requests arriving during the other CPU's ACC/DONE are only evaluated at release; there is no preemption.
- Round-robin guarantees neither CPU waits more than one foreign access.
- reset asserted in any state → outputs to reset values at the next edge; any in-flight write strobe is terminated.
- ab_sel never changes while in an ACC state.
- vram_we_n is never low outside ACC states.

Test Plan:
1. Single A write, ACC_CYCLES=2, a_req=a_wr=1 from cycle 0:
   - a_wait_n = 0 in cycles 0–2 (ACC_A in cycles 1–2), vram_we_n = 0 in cycles 1–2, ab_sel = 0.
   - DONE_A in cycle 3 with a_wait_n = 1.
   - a_req = 0 in cycle 5 → IDLE in cycle 6, busy = 0.
2. Simultaneous a_req = b_req = 1 right after reset:
   - A granted first; b_wait_n = 0 throughout.
   - On A release, ACC_B on the next edge (ab_sel = 1, no IDLE cycle); b_wait_n = 1 two cycles later in DONE_B.
3. Continuous simultaneous requests over 4 accesses → grants alternate A, B, A, B; ab_sel toggles once per grant; no CPU receives two consecutive grants.
4. Abort: b_req drops in the first ACC_B cycle of a write → IDLE next edge; vram_we_n low for 1 cycle only; last_grant = B, so the next tie goes to A.
5. Reset asserted mid-ACC_A (write) for 1 cycle → vram_we_n = 1, ab_sel = PARK_SEL, busy = 0 at the next edge; a_wait_n = 1 during reset; re-arbitration proceeds normally afterwards.
6. ACC_CYCLES=1, single B read → ACC_B for exactly 1 cycle, vram_we_n stays 1, b_wait_n low for 2 cycles total.
